// File: rtl/clk_div_cfg_ctrl_pkg.sv
// Shared encodings for the clock-divider configuration sequencer:
// FSM states, requester ids and the counter sizing helper.
package clk_div_cfg_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATE   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

   // Width needed to hold the longer of the two wait intervals.
   function automatic int cnt_width(input int drain_cyc, input int settle_cyc);
      int max_cyc;
      max_cyc = (drain_cyc > settle_cyc) ? drain_cyc : settle_cyc;
      return ($clog2(max_cyc + 1) < 1) ? 1 : $clog2(max_cyc + 1);
   endfunction

endpackage

// File: rtl/clk_div_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins;
// the last-grant register only moves when the caller strobes update.
module clk_div_rr_arb
   import clk_div_cfg_ctrl_pkg::*;
(
   input  logic i_ref_clk,
   input  logic i_rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic update,
   output logic gnt_valid,
   output logic gnt_id
);

   logic last_q;

   always_comb begin
      gnt_valid = req_a | req_b;
      if (req_a && req_b) begin
         gnt_id = ~last_q;
      end else if (req_b) begin
         gnt_id = REQ_B;
      end else begin
         gnt_id = REQ_A;
      end
   end

   // Resetting to B lets A win the first tie after reset.
   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         last_q <= REQ_B;
      end else if (update && gnt_valid) begin
         last_q <= gnt_id;
      end
   end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequences ratio changes for a shared clock divider: gate the enable, load
// the new ratio, re-enable, settle, then hold ack until the requester drops.
module clk_div_cfg_ctrl
   import clk_div_cfg_ctrl_pkg::*;
#(
   parameter int RATIO_WD   = 8,
   parameter int DEF_RATIO  = 8,
   parameter int DRAIN_CYC  = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                i_ref_clk,
   input  logic                i_rst_n,
   input  logic                i_sys_en,
   input  logic                i_req_a,
   input  logic [RATIO_WD-1:0] i_ratio_a,
   output logic                o_ack_a,
   input  logic                i_req_b,
   input  logic [RATIO_WD-1:0] i_ratio_b,
   output logic                o_ack_b,
   output logic [RATIO_WD-1:0] o_div_ratio,
   output logic                o_clk_en,
   output logic                o_busy
);

   localparam int                CNT_WD      = cnt_width(DRAIN_CYC, SETTLE_CYC);
   localparam logic [CNT_WD-1:0] DRAIN_LAST  = CNT_WD'(DRAIN_CYC - 1);
   localparam logic [CNT_WD-1:0] SETTLE_LAST = CNT_WD'(SETTLE_CYC - 1);
   localparam logic [CNT_WD-1:0] CNT_SAT     = '1;

   state_e              state_q, state_d;
   logic [CNT_WD-1:0]   cnt_q, cnt_d;
   logic [RATIO_WD-1:0] ratio_q, ratio_d;
   logic [RATIO_WD-1:0] cap_ratio_q, cap_ratio_d;
   req_id_e             gnt_id_q, gnt_id_d;

   logic                arb_valid;
   logic                arb_gnt;
   logic                arb_update;
   logic [RATIO_WD-1:0] arb_ratio;
   logic                gnt_req;

   clk_div_rr_arb u_arb (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .req_a     (i_req_a),
      .req_b     (i_req_b),
      .update    (arb_update),
      .gnt_valid (arb_valid),
      .gnt_id    (arb_gnt)
   );

   assign arb_ratio = (req_id_e'(arb_gnt) == REQ_A) ? i_ratio_a : i_ratio_b;
   assign gnt_req   = (gnt_id_q == REQ_A) ? i_req_a : i_req_b;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ratio_d     = ratio_q;
      cap_ratio_d = cap_ratio_q;
      gnt_id_d    = gnt_id_q;
      arb_update  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               arb_update  = 1'b1;
               gnt_id_d    = req_id_e'(arb_gnt);
               cap_ratio_d = arb_ratio;
               cnt_d       = '0;
               state_d     = (arb_ratio == ratio_q) ? ST_DONE : ST_GATE;
            end
         end
         ST_GATE: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = ST_LOAD;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LOAD: begin
            ratio_d = cap_ratio_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_DONE;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            // Leave only once the granted requester lets go; IDLE re-arbitrates next cycle.
            if (!gnt_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ratio_q     <= RATIO_WD'(DEF_RATIO);
         cap_ratio_q <= '0;
         gnt_id_q    <= REQ_A;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ratio_q     <= ratio_d;
         cap_ratio_q <= cap_ratio_d;
         gnt_id_q    <= gnt_id_d;
      end
   end

   assign o_div_ratio = ratio_q;
   assign o_clk_en    = i_sys_en && (state_q != ST_GATE) && (state_q != ST_LOAD);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_ack_a     = (state_q == ST_DONE) && (gnt_id_q == REQ_A);
   assign o_ack_b     = (state_q == ST_DONE) && (gnt_id_q == REQ_B);

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: a vector table of single-requester
// changes plus hand-written arbitration, mid-sequence reset and pulse cases.
module tb_clk_div_cfg_ctrl;

   localparam int RATIO_WD   = 8;
   localparam int DEF_RATIO  = 8;
   localparam int DRAIN_CYC  = 4;
   localparam int SETTLE_CYC = 2;

   localparam int LAT_CHG  = DRAIN_CYC + SETTLE_CYC + 2;
   localparam int CHG_CYC  = DRAIN_CYC + 2;
   localparam int GATE_LEN = DRAIN_CYC + 1;
   localparam int BUDGET   = 40;

   logic                i_ref_clk = 1'b0;
   logic                i_rst_n;
   logic                i_sys_en;
   logic                i_req_a;
   logic [RATIO_WD-1:0] i_ratio_a;
   logic                o_ack_a;
   logic                i_req_b;
   logic [RATIO_WD-1:0] i_ratio_b;
   logic                o_ack_b;
   logic [RATIO_WD-1:0] o_div_ratio;
   logic                o_clk_en;
   logic                o_busy;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct packed {
      logic          id;
      logic [7:0]    ratio;
      int            lat;
      int            gate;
      int            chg;
   } exp_t;

   typedef struct packed {
      logic          id;
      logic [7:0]    ratio;
      logic          sys_en;
      logic [7:0]    exp_ratio;
      int            exp_lat;
      int            exp_gate;
      int            exp_chg;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[7];

   clk_div_cfg_ctrl #(
      .RATIO_WD   (RATIO_WD),
      .DEF_RATIO  (DEF_RATIO),
      .DRAIN_CYC  (DRAIN_CYC),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_sys_en    (i_sys_en),
      .i_req_a     (i_req_a),
      .i_ratio_a   (i_ratio_a),
      .o_ack_a     (o_ack_a),
      .i_req_b     (i_req_b),
      .i_ratio_b   (i_ratio_b),
      .o_ack_b     (o_ack_b),
      .o_div_ratio (o_div_ratio),
      .o_clk_en    (o_clk_en),
      .o_busy      (o_busy)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle(input string name);
      check({name, " ratio"}, 32'(o_div_ratio), 32'(DEF_RATIO));
      check({name, " ack_a"}, 32'(o_ack_a), 0);
      check({name, " ack_b"}, 32'(o_ack_b), 0);
      check({name, " busy"}, 32'(o_busy), 0);
      check({name, " clk_en"}, 32'(o_clk_en), 32'(i_sys_en));
   endtask

   task automatic push_exp(input logic id, input logic [7:0] ratio, input int lat,
                           input int gate, input int chg);
      exp_t e;
      e.id    = id;
      e.ratio = ratio;
      e.lat   = lat;
      e.gate  = gate;
      e.chg   = chg;
      sb_q.push_back(e);
   endtask

   // Observes one negedge per cycle until the expected ack appears, then
   // compares latency, gated cycles and the cycle the new ratio appeared.
   task automatic wait_ack(input string name, input int drop_k);
      exp_t e;
      int   k;
      int   gate;
      int   chg;
      logic seen;
      logic other;
      e     = sb_q.pop_front();
      k     = 0;
      gate  = 0;
      chg   = 0;
      seen  = 1'b0;
      other = 1'b0;
      while (!seen && k < BUDGET) begin
         @(negedge i_ref_clk);
         k++;
         if (!o_clk_en) gate++;
         if (chg == 0 && o_div_ratio == e.ratio) chg = k;
         if (e.id ? o_ack_a : o_ack_b) other = 1'b1;
         if (e.id ? o_ack_b : o_ack_a) seen = 1'b1;
         if (k == drop_k) begin
            if (e.id) begin
               i_req_b   = 1'b0;
               i_ratio_b = 8'h63;
            end else begin
               i_req_a   = 1'b0;
               i_ratio_a = 8'h63;
            end
         end
      end
      check({name, " ack seen"}, 32'(seen), 1);
      check({name, " ack latency"}, 32'(k), 32'(e.lat));
      check({name, " gated cycles"}, 32'(gate), 32'(e.gate));
      check({name, " ratio change cycle"}, 32'(chg), 32'(e.chg));
      check({name, " ratio at ack"}, 32'(o_div_ratio), 32'(e.ratio));
      check({name, " other ack"}, 32'(other), 0);
      check({name, " busy at ack"}, 32'(o_busy), 1);
   endtask

   task automatic finish_seq(input string name, input logic id);
      if (id) i_req_b = 1'b0;
      else    i_req_a = 1'b0;
      @(negedge i_ref_clk);
      check({name, " ack_a after drop"}, 32'(o_ack_a), 0);
      check({name, " ack_b after drop"}, 32'(o_ack_b), 0);
      check({name, " busy after drop"}, 32'(o_busy), 0);
      check({name, " clk_en after drop"}, 32'(o_clk_en), 32'(i_sys_en));
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_req_a = 1'b0;
      i_req_b = 1'b0;
      repeat (3) @(negedge i_ref_clk);
      i_rst_n = 1'b1;
      @(negedge i_ref_clk);
   endtask

   initial begin
      vecs[0] = '{id: 1'b0, ratio: 8'd5,   sys_en: 1'b1, exp_ratio: 8'd5,   exp_lat: LAT_CHG, exp_gate: GATE_LEN, exp_chg: CHG_CYC};
      vecs[1] = '{id: 1'b1, ratio: 8'd5,   sys_en: 1'b1, exp_ratio: 8'd5,   exp_lat: 1,       exp_gate: 0,        exp_chg: 1};
      vecs[2] = '{id: 1'b1, ratio: 8'd0,   sys_en: 1'b1, exp_ratio: 8'd0,   exp_lat: LAT_CHG, exp_gate: GATE_LEN, exp_chg: CHG_CYC};
      vecs[3] = '{id: 1'b0, ratio: 8'd1,   sys_en: 1'b1, exp_ratio: 8'd1,   exp_lat: LAT_CHG, exp_gate: GATE_LEN, exp_chg: CHG_CYC};
      vecs[4] = '{id: 1'b0, ratio: 8'd8,   sys_en: 1'b1, exp_ratio: 8'd8,   exp_lat: LAT_CHG, exp_gate: GATE_LEN, exp_chg: CHG_CYC};
      vecs[5] = '{id: 1'b1, ratio: 8'd8,   sys_en: 1'b1, exp_ratio: 8'd8,   exp_lat: 1,       exp_gate: 0,        exp_chg: 1};
      vecs[6] = '{id: 1'b0, ratio: 8'd200, sys_en: 1'b0, exp_ratio: 8'd200, exp_lat: LAT_CHG, exp_gate: LAT_CHG,  exp_chg: CHG_CYC};

      i_sys_en  = 1'b1;
      i_ratio_a = '0;
      i_ratio_b = '0;
      do_reset();
      check_idle("reset");

      for (int i = 0; i < 7; i++) begin
         i_sys_en = vecs[i].sys_en;
         if (vecs[i].id) begin
            i_req_b   = 1'b1;
            i_ratio_b = vecs[i].ratio;
         end else begin
            i_req_a   = 1'b1;
            i_ratio_a = vecs[i].ratio;
         end
         push_exp(vecs[i].id, vecs[i].ratio, vecs[i].exp_lat, vecs[i].exp_gate, vecs[i].exp_chg);
         wait_ack($sformatf("vec%0d", i), 0);
         check($sformatf("vec%0d final ratio", i), 32'(o_div_ratio), 32'(vecs[i].exp_ratio));
         finish_seq($sformatf("vec%0d", i), vecs[i].id);
         i_sys_en = 1'b1;
      end

      // Tie straight after reset: A first, B held pending until A releases.
      do_reset();
      check_idle("reset2");
      i_req_a   = 1'b1;
      i_ratio_a = 8'd3;
      i_req_b   = 1'b1;
      i_ratio_b = 8'd7;
      push_exp(1'b0, 8'd3, LAT_CHG, GATE_LEN, CHG_CYC);
      wait_ack("tie_a", 0);
      push_exp(1'b1, 8'd7, LAT_CHG + 1, GATE_LEN, CHG_CYC + 1);
      i_req_a = 1'b0;
      wait_ack("tie_b", 0);
      finish_seq("tie_b", 1'b1);

      // Reset while gating abandons the ratio-12 change.
      i_req_a   = 1'b1;
      i_ratio_a = 8'd12;
      @(negedge i_ref_clk);
      check("gate busy", 32'(o_busy), 1);
      check("gate clk_en", 32'(o_clk_en), 0);
      @(negedge i_ref_clk);
      i_rst_n = 1'b0;
      i_req_a = 1'b0;
      @(negedge i_ref_clk);
      check_idle("mid reset");
      i_rst_n = 1'b1;
      @(negedge i_ref_clk);
      check_idle("post reset");

      // One-cycle request pulse; ratio input scrambled after the grant.
      i_req_a   = 1'b1;
      i_ratio_a = 8'd2;
      push_exp(1'b0, 8'd2, LAT_CHG, GATE_LEN, CHG_CYC);
      wait_ack("pulse", 1);
      finish_seq("pulse", 1'b0);
      check("pulse final ratio", 32'(o_div_ratio), 32'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
Sequences run-time division-ratio changes for one shared clock divider (RATIO_WD-bit ratio, enable input, bypass at ratio 0/1), driven from the reference-clock domain.
Two configuration requesters (e.g. UART prescale and system config) share the divider through round-robin arbitration.
Every change gates the divider enable, loads the new ratio, then re-enables and waits a settle interval before acknowledging, so the divider never sees a ratio change while it is counting.

Parameters:
RATIO_WD, 8, width of division ratio
DEF_RATIO, 8, ratio driven after reset
DRAIN_CYC, 4, cycles the enable is held low before the ratio load (min 1)
SETTLE_CYC, 2, cycles after re-enable before ack (min 1)

Ports:
i_ref_clk  in  1  reference clock, sole clock
i_rst_n  in  1  reset, synchronous, active-low
i_sys_en  in  1  global divider enable request
i_req_a  in  1  requester A change request (level)
i_ratio_a  in  RATIO_WD  requester A ratio, sampled at grant
o_ack_a  out  1  requester A done (level)
i_req_b  in  1  requester B change request (level)
i_ratio_b  in  RATIO_WD  requester B ratio, sampled at grant
o_ack_b  out  1  requester B done (level)
o_div_ratio  out  RATIO_WD  ratio to divider
o_clk_en  out  1  enable to divider
o_busy  out  1  sequence in progress (state != IDLE)

Behaviour:
- Reset (i_rst_n low at posedge): state IDLE, o_div_ratio=DEF_RATIO, acks 0, counter 0, last-grant = B (so A wins the first tie). Applies mid-sequence too: the sequence is abandoned and the captured ratio discarded.
- o_clk_en = i_sys_en AND state not in {GATE, LOAD}. It is decoded from the state register only.
- o_ack_x = (state==DONE) AND (grant==x).
- FSM states: IDLE, GATE, LOAD, SETTLE, DONE.
- IDLE:
  - Arbitrate among asserted reqs. On a tie, grant the requester not granted last.
  - Capture the granted ratio and grant id, and update last-grant.
  - If the captured ratio equals o_div_ratio, go to DONE (no gating). Otherwise go to GATE and clear the counter.
- GATE: count DRAIN_CYC cycles, then LOAD.
- LOAD: one cycle. o_div_ratio takes the captured ratio at the end of this cycle. Go to SETTLE and clear the counter.
- SETTLE: count SETTLE_CYC cycles, then DONE.
- DONE:
  - Ack is high.
  - Return to IDLE on the first cycle the granted req is low (four-phase handshake).
  - Arbitration resumes in IDLE the following cycle. This prevents a still-high req from being re-granted.
- Latency with req sampled in IDLE at cycle T:
  - GATE T+1..T+DRAIN_CYC.
  - LOAD T+DRAIN_CYC+1.
  - New ratio visible from T+DRAIN_CYC+2.
  - SETTLE for SETTLE_CYC cycles.
  - Ack from T+DRAIN_CYC+SETTLE_CYC+2.
  - Same-ratio request: ack from T+1.
- Requester ratio inputs are ignored except in the IDLE grant cycle. Changes mid-sequence have no effect.
- Granted req dropping before DONE: the sequence still completes. DONE then exits after one cycle, and ack is a one-cycle pulse.
- Non-granted req: held pending and not acked. It is served after the current sequence returns to IDLE.
- Ratio 0 or 1 is accepted and loaded like any other value. The divider itself treats these as bypass.
- i_sys_en low: the FSM still runs and loads the ratio normally, and o_clk_en stays 0.
- Counter width: clog2(max(DRAIN_CYC, SETTLE_CYC)+1). The counter saturates, never wraps.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams) and the requester-id encoding (A=0, B=1).
- One natural sub-module: clk_div_rr_arb, a 2-way round-robin arbiter with a last-grant register and an update strobe. The FSM and datapath registers stay in the top level.

Test Plan:
1. Reset release, i_sys_en=1, no reqs -> o_div_ratio=8, o_clk_en=1, o_busy=0, acks 0.
2. req_a with ratio_a=5 at T (DRAIN=4, SETTLE=2) -> o_clk_en=0 T+1..T+5; o_div_ratio=5 from T+6; o_clk_en=1 from T+6; o_ack_a rises T+8 and falls the cycle after req_a drops.
3. req_a and req_b both high in IDLE after reset (ratios 3, 7) -> A served first (ratio 3, ack_a); after req_a drops, B granted (ratio 7); B is never acked during A's sequence.
4. req_b with ratio_b=8 (equal to current) -> no gating cycle, o_clk_en stays 1, o_ack_b high at T+1.
5. Reset asserted during GATE of a ratio-12 request -> next cycle IDLE, o_div_ratio=8, acks 0, o_clk_en=i_sys_en.
6. req_a pulsed for one cycle with ratio 2 -> full sequence completes, o_div_ratio=2, o_ack_a is a single-cycle pulse, then IDLE.
